cv32e40p_apu_wb_buffer: RTL and testbench
=========================================

Name: cv32e40p_apu_wb_buffer

Overview:
- Sits directly downstream of the APU dispatcher, between the APU response channel and register-file write port B.
- APU responses carry no ready signal and cannot be back-pressured. This block captures every response (result, flags and the dispatcher-supplied destination address) and retires it in order to port B whenever the LSU/ALU does not own that port.
- It reports RAW/WAW hazards on buffered-but-unwritten results to the ID stage.

Parameters:
- DEPTH, 3, number of buffered results (dispatcher allows at most 3 outstanding); legal range 2..4, need not be a power of two.
- DATA_WIDTH, 32, APU result width.
- FLAGS_WIDTH, 5, FP exception flag width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- setback_i  in  1  synchronous flush, same cycle as dispatcher setback
- is_decoding_i  in  1  ID stage is decoding a valid instruction
- apu_rvalid_i  in  1  APU response valid
- apu_result_i  in  DATA_WIDTH  APU result
- apu_flags_i  in  FLAGS_WIDTH  APU exception flags
- apu_waddr_i  in  6  destination register of returning op, from dispatcher
- wb_port_busy_i  in  1  port B claimed this cycle by a higher-priority writer
- regfile_we_o  out  1  port B write enable
- regfile_waddr_o  out  6  port B address
- regfile_wdata_o  out  DATA_WIDTH  port B data
- fflags_we_o  out  1  FP flags update enable
- fflags_o  out  FLAGS_WIDTH  flags to CSR
- read_regs_i  in  3x6  ID source registers
- read_regs_valid_i  in  3  source valid
- read_dep_o  out  1  RAW hazard on a pending result
- write_regs_i  in  2x6  ID destination registers
- write_regs_valid_i  in  2  destination valid
- write_dep_o  out  1  WAW hazard on a pending result
- empty_o  out  1  no pending entries
- full_o  out  1  DEPTH entries pending
- overflow_o  out  1  sticky: a response was dropped

Behaviour:
- Reset: rst_ni is asynchronous, active-low, clock is clk_i. On reset: count=0, rd_ptr=wr_ptr=0, all entry valids 0, overflow_o=0. All write outputs are 0 and empty_o=1.
- Storage: circular buffer of DEPTH entries {waddr, result, flags}. Pointers wrap from DEPTH-1 to 0. count ranges 0..DEPTH.
- pop = !empty & !wb_port_busy_i. The head entry drives the regfile/fflags outputs, with we=1, in the same cycle.
- bypass = empty & apu_rvalid_i & !wb_port_busy_i. The response is written combinationally the same cycle (0 latency) and not stored.
- push = apu_rvalid_i & !bypass.
  - Push into a non-full buffer, or into a full buffer while popping in the same cycle: stored at wr_ptr. Results visible at port B no earlier than the next cycle.
- Push while full and not popping: response dropped, overflow_o set. overflow_o stays set until reset or setback. This is a protocol violation; assertion required.
- Ordering: strict FIFO. A non-empty buffer never bypasses, so it never reorders.
- Simultaneous push+pop: count unchanged, both pointers advance.
- Port output when idle (no pop, no bypass): we=0, waddr=0, wdata=0, fflags=0.
- Hazard set H = all valid entries (including the head being popped this cycle), plus the incoming response when push=1.
  - read_dep_o = is_decoding_i & any valid read reg matching an address in H.
  - write_dep_o = same, using write regs.
  - A bypassed response is never in H.
- setback_i: next cycle count=0, pointers=0, all valids cleared, overflow cleared. A response arriving in the setback cycle is discarded. Outputs in the setback cycle still follow the current-cycle rules.
- full_o = (count==DEPTH). empty_o = (count==0). Both are registered-state-derived with no combinational dependence on inputs.

Test Plan:
- Empty, port free, rvalid with waddr=5, result=0xDEADBEEF, flags=0x01 -> same cycle: we=1, waddr=5, wdata=0xDEADBEEF, fflags_we=1; empty_o stays 1.
- wb_port_busy_i=1 for 3 cycles while responses to regs 3, 4, 7 arrive -> full_o=1 after 3rd cycle. Busy drops -> writes 3, 4, 7 on consecutive cycles in that order; empty_o=1 afterwards.
- Entry for reg 9 pending, ID reads reg 9 with is_decoding_i=1 -> read_dep_o=1. Write reg 9 -> write_dep_o=1. is_decoding_i=0 -> both 0.
- Full (DEPTH=3), busy=1, extra rvalid -> overflow_o=1, count stays 3. Same with busy=0 -> head written, new entry stored, overflow_o=0.
- Wrap-around: push/pop 7 responses with alternating busy -> writes in exact arrival order across pointer wrap 2->0.
- Two entries pending, setback_i=1 with concurrent rvalid -> next cycle empty_o=1, overflow_o=0, no further writes, deps=0.

Source files
------------

// File: rtl/cv32e40p_apu_wb_buffer.sv
// Write-back buffer between the APU response channel and register-file port B.
// Captures every non-back-pressurable APU response, retires in order, and flags RAW/WAW hazards.
module cv32e40p_apu_wb_buffer #(
    parameter int unsigned DEPTH           = 3,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned FLAGS_WIDTH     = 5,
    parameter bit          OVERFLOW_ASSERT = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   setback_i,
    input  logic                   is_decoding_i,
    input  logic                   apu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]  apu_result_i,
    input  logic [FLAGS_WIDTH-1:0] apu_flags_i,
    input  logic [5:0]             apu_waddr_i,
    input  logic                   wb_port_busy_i,
    output logic                   regfile_we_o,
    output logic [5:0]             regfile_waddr_o,
    output logic [DATA_WIDTH-1:0]  regfile_wdata_o,
    output logic                   fflags_we_o,
    output logic [FLAGS_WIDTH-1:0] fflags_o,
    input  logic [2:0][5:0]        read_regs_i,
    input  logic [2:0]             read_regs_valid_i,
    output logic                   read_dep_o,
    input  logic [1:0][5:0]        write_regs_i,
    input  logic [1:0]             write_regs_valid_i,
    output logic                   write_dep_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic                   overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [5:0]             waddr;
        logic [DATA_WIDTH-1:0]  result;
        logic [FLAGS_WIDTH-1:0] flags;
    } entry_t;

    entry_t           entry_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;

    logic empty;
    logic full;
    logic pop;
    logic bypass;
    logic push;
    logic store;
    logic drop;
    logic read_hit;
    logic write_hit;

    // Non-power-of-two depth: pointers wrap explicitly instead of by overflow.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign empty  = (count_q == '0);
    assign full   = (count_q == DEPTH_CNT);
    assign pop    = !empty && !wb_port_busy_i;
    assign bypass = empty && apu_rvalid_i && !wb_port_busy_i;
    assign push   = apu_rvalid_i && !bypass;
    assign store  = push && (!full || pop);
    assign drop   = push && full && !pop;

    assign empty_o    = empty;
    assign full_o     = full;
    assign overflow_o = overflow_q;

    always_comb begin
        regfile_we_o    = 1'b0;
        regfile_waddr_o = '0;
        regfile_wdata_o = '0;
        fflags_we_o     = 1'b0;
        fflags_o        = '0;
        if (pop) begin
            regfile_we_o    = 1'b1;
            regfile_waddr_o = entry_q[rd_ptr_q].waddr;
            regfile_wdata_o = entry_q[rd_ptr_q].result;
            fflags_we_o     = 1'b1;
            fflags_o        = entry_q[rd_ptr_q].flags;
        end else if (bypass) begin
            regfile_we_o    = 1'b1;
            regfile_waddr_o = apu_waddr_i;
            regfile_wdata_o = apu_result_i;
            fflags_we_o     = 1'b1;
            fflags_o        = apu_flags_i;
        end
    end

    // Hazard set: every valid entry (head included even while popping) plus a response being stored.
    always_comb begin
        read_hit  = 1'b0;
        write_hit = 1'b0;
        for (int r = 0; r < 3; r++) begin
            if (read_regs_valid_i[r]) begin
                for (int e = 0; e < int'(DEPTH); e++) begin
                    if (valid_q[e] && (entry_q[e].waddr == read_regs_i[r])) read_hit = 1'b1;
                end
                if (push && (apu_waddr_i == read_regs_i[r])) read_hit = 1'b1;
            end
        end
        for (int w = 0; w < 2; w++) begin
            if (write_regs_valid_i[w]) begin
                for (int e = 0; e < int'(DEPTH); e++) begin
                    if (valid_q[e] && (entry_q[e].waddr == write_regs_i[w])) write_hit = 1'b1;
                end
                if (push && (apu_waddr_i == write_regs_i[w])) write_hit = 1'b1;
            end
        end
    end

    assign read_dep_o  = is_decoding_i && read_hit;
    assign write_dep_o = is_decoding_i && write_hit;

    // NOTE: payload storage has no reset; valid_q alone decides whether an entry means anything.
    always_ff @(posedge clk_i) begin
        if (store) entry_q[wr_ptr_q] <= '{waddr: apu_waddr_i, result: apu_result_i, flags: apu_flags_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (setback_i) begin
            valid_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= ptr_inc(rd_ptr_q);
            end
            // NOTE: when full, push and pop hit the same slot; the later set must win over the clear.
            if (store) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            if (drop) overflow_q <= 1'b1;
            case ({store, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // A dropped response means the dispatcher let more than DEPTH results be outstanding.
    if (OVERFLOW_ASSERT) begin : g_overflow_check
        a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni) !(drop && !setback_i));
    end

endmodule

// File: tb/tb_cv32e40p_apu_wb_buffer.sv
// Self-checking bench for cv32e40p_apu_wb_buffer: directed vector table, arrival-order
// wrap sequence, and randomized traffic against a queue-based reference model.
module tb_cv32e40p_apu_wb_buffer;

    localparam int DEPTH = 3;
    localparam int DW    = 32;
    localparam int FW    = 5;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic            setback_i, is_decoding_i, apu_rvalid_i, wb_port_busy_i;
    logic [DW-1:0]   apu_result_i;
    logic [FW-1:0]   apu_flags_i;
    logic [5:0]      apu_waddr_i;
    logic            regfile_we_o, fflags_we_o;
    logic [5:0]      regfile_waddr_o;
    logic [DW-1:0]   regfile_wdata_o;
    logic [FW-1:0]   fflags_o;
    logic [2:0][5:0] read_regs_i;
    logic [2:0]      read_regs_valid_i;
    logic            read_dep_o;
    logic [1:0][5:0] write_regs_i;
    logic [1:0]      write_regs_valid_i;
    logic            write_dep_o, empty_o, full_o, overflow_o;

    // Overflow is exercised on purpose, so the protocol assertion is disabled here.
    cv32e40p_apu_wb_buffer #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .FLAGS_WIDTH(FW), .OVERFLOW_ASSERT(1'b0)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .setback_i(setback_i), .is_decoding_i(is_decoding_i),
        .apu_rvalid_i(apu_rvalid_i), .apu_result_i(apu_result_i), .apu_flags_i(apu_flags_i),
        .apu_waddr_i(apu_waddr_i), .wb_port_busy_i(wb_port_busy_i),
        .regfile_we_o(regfile_we_o), .regfile_waddr_o(regfile_waddr_o),
        .regfile_wdata_o(regfile_wdata_o), .fflags_we_o(fflags_we_o), .fflags_o(fflags_o),
        .read_regs_i(read_regs_i), .read_regs_valid_i(read_regs_valid_i), .read_dep_o(read_dep_o),
        .write_regs_i(write_regs_i), .write_regs_valid_i(write_regs_valid_i),
        .write_dep_o(write_dep_o), .empty_o(empty_o), .full_o(full_o), .overflow_o(overflow_o)
    );

    typedef struct packed {
        logic            sb, dec, rv;
        logic [5:0]      waddr;
        logic [DW-1:0]   result;
        logic [FW-1:0]   flags;
        logic            busy;
        logic [2:0][5:0] rr;
        logic [2:0]      rrv;
        logic [1:0][5:0] wr;
        logic [1:0]      wrv;
    } in_t;

    typedef struct packed {
        logic          we;
        logic [5:0]    waddr;
        logic [DW-1:0] wdata;
        logic          fwe;
        logic [FW-1:0] fflags;
        logic          rdep, wdep, empty, full, ovf;
    } out_t;

    typedef struct packed { in_t in; out_t exp; } vec_t;
    typedef struct packed { logic [5:0] waddr; logic [DW-1:0] result; logic [FW-1:0] flags; } ent_t;

    ent_t       mq[$];
    bit         m_ovf;
    vec_t       tbl[$];
    logic [5:0] wr_log[$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic in_t mk_in(input bit sb, dec, rv, input logic [5:0] wa, input logic [DW-1:0] res,
                                  input logic [FW-1:0] fl, input bit busy, input logic [17:0] rr,
                                  input logic [2:0] rrv, input logic [11:0] wr, input logic [1:0] wrv);
        in_t i;
        i = '{sb: sb, dec: dec, rv: rv, waddr: wa, result: res, flags: fl, busy: busy,
              rr: rr, rrv: rrv, wr: wr, wrv: wrv};
        return i;
    endfunction

    function automatic in_t sim(input bit busy, rv, input logic [5:0] wa, input logic [DW-1:0] res,
                                input logic [FW-1:0] fl);
        return mk_in(1'b0, 1'b0, rv, wa, res, fl, busy, '0, '0, '0, '0);
    endfunction

    function automatic out_t mk_out(input bit we, input logic [5:0] wa, input logic [DW-1:0] wd,
                                    input logic [FW-1:0] fl, input bit rdep, wdep, empty, full, ovf);
        out_t o;
        o = '{we: we, waddr: wa, wdata: wd, fwe: we, fflags: fl, rdep: rdep, wdep: wdep,
              empty: empty, full: full, ovf: ovf};
        return o;
    endfunction

    function automatic out_t idle_out(input bit empty, full, ovf);
        return mk_out(1'b0, '0, '0, '0, 1'b0, 1'b0, empty, full, ovf);
    endfunction

    function automatic void add(input in_t i, input out_t o);
        tbl.push_back('{in: i, exp: o});
    endfunction

    // Reference model: an ordered list of pending results plus a sticky overflow bit.
    function automatic bit pending_hit(input logic [5:0] r, input bit incoming, input logic [5:0] inc);
        foreach (mq[k]) if (mq[k].waddr == r) return 1'b1;
        return incoming && (inc == r);
    endfunction

    function automatic out_t model_out(input in_t i);
        out_t o;
        bit   bypass, push;
        o      = '0;
        bypass = (mq.size() == 0) && i.rv && !i.busy;
        push   = i.rv && !bypass;
        if (mq.size() != 0 && !i.busy) begin
            o.we = 1'b1; o.waddr = mq[0].waddr; o.wdata = mq[0].result; o.fflags = mq[0].flags;
        end else if (bypass) begin
            o.we = 1'b1; o.waddr = i.waddr; o.wdata = i.result; o.fflags = i.flags;
        end
        o.fwe = o.we;
        for (int r = 0; r < 3; r++)
            if (i.dec && i.rrv[r] && pending_hit(i.rr[r], push, i.waddr)) o.rdep = 1'b1;
        for (int w = 0; w < 2; w++)
            if (i.dec && i.wrv[w] && pending_hit(i.wr[w], push, i.waddr)) o.wdep = 1'b1;
        o.empty = (mq.size() == 0);
        o.full  = (mq.size() == DEPTH);
        o.ovf   = m_ovf;
        return o;
    endfunction

    function automatic void model_step(input in_t i);
        bit bypass, push;
        bypass = (mq.size() == 0) && i.rv && !i.busy;
        push   = i.rv && !bypass;
        if (i.sb) begin
            mq.delete();
            m_ovf = 1'b0;
            return;
        end
        if (mq.size() != 0 && !i.busy) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back('{waddr: i.waddr, result: i.result, flags: i.flags});
            else m_ovf = 1'b1;
        end
    endfunction

    task automatic drive(input in_t i);
        setback_i          = i.sb;
        is_decoding_i      = i.dec;
        apu_rvalid_i       = i.rv;
        apu_waddr_i        = i.waddr;
        apu_result_i       = i.result;
        apu_flags_i        = i.flags;
        wb_port_busy_i     = i.busy;
        read_regs_i        = i.rr;
        read_regs_valid_i  = i.rrv;
        write_regs_i       = i.wr;
        write_regs_valid_i = i.wrv;
    endtask

    task automatic compare(input out_t e, input string tag);
        check({tag, " we"},        regfile_we_o,    e.we);
        check({tag, " waddr"},     regfile_waddr_o, e.waddr);
        check({tag, " wdata"},     regfile_wdata_o, e.wdata);
        check({tag, " fflags_we"}, fflags_we_o,     e.fwe);
        check({tag, " fflags"},    fflags_o,        e.fflags);
        check({tag, " read_dep"},  read_dep_o,      e.rdep);
        check({tag, " write_dep"}, write_dep_o,     e.wdep);
        check({tag, " empty"},     empty_o,         e.empty);
        check({tag, " full"},      full_o,          e.full);
        check({tag, " overflow"},  overflow_o,      e.ovf);
    endtask

    // One cycle: drive at negedge, compare mid-phase, then advance the model.
    task automatic apply(input in_t i, input bit use_tbl, input out_t tbl_exp, input string tag);
        out_t m;
        @(negedge clk_i);
        drive(i);
        #2;
        m = model_out(i);
        compare(use_tbl ? tbl_exp : m, tag);
        if (regfile_we_o === 1'b1) wr_log.push_back(regfile_waddr_o);
        model_step(i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t rnd;
        drive('0);
        m_ovf = 1'b0;

        // Same-cycle bypass into an empty buffer.
        add(sim(0, 1, 6'd5, 32'hDEADBEEF, 5'h01), mk_out(1, 6'd5, 32'hDEADBEEF, 5'h01, 0, 0, 1, 0, 0));
        add(sim(0, 0, 0, 0, 0), idle_out(1, 0, 0));
        // Port busy for three responses, then in-order drain.
        add(sim(1, 1, 6'd3, 32'h33, 5'h02), idle_out(1, 0, 0));
        add(sim(1, 1, 6'd4, 32'h44, 5'h03), idle_out(0, 0, 0));
        add(sim(1, 1, 6'd7, 32'h77, 5'h04), idle_out(0, 0, 0));
        add(sim(0, 0, 0, 0, 0), mk_out(1, 6'd3, 32'h33, 5'h02, 0, 0, 0, 1, 0));
        add(sim(0, 0, 0, 0, 0), mk_out(1, 6'd4, 32'h44, 5'h03, 0, 0, 0, 0, 0));
        add(sim(0, 0, 0, 0, 0), mk_out(1, 6'd7, 32'h77, 5'h04, 0, 0, 0, 0, 0));
        add(sim(0, 0, 0, 0, 0), idle_out(1, 0, 0));
        // Hazards against a pending result for reg 9.
        add(mk_in(0, 1, 1, 6'd9, 32'h99, 5'h00, 1, {6'd0, 6'd0, 6'd9}, 3'b001, '0, 2'b00),
            mk_out(0, 0, 0, 0, 1, 0, 1, 0, 0));
        add(mk_in(0, 1, 0, 0, 0, 0, 1, {6'd0, 6'd0, 6'd9}, 3'b001, {6'd0, 6'd9}, 2'b01),
            mk_out(0, 0, 0, 0, 1, 1, 0, 0, 0));
        add(mk_in(0, 0, 0, 0, 0, 0, 1, {6'd0, 6'd0, 6'd9}, 3'b001, {6'd0, 6'd9}, 2'b01),
            mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(mk_in(0, 1, 0, 0, 0, 0, 1, {6'd0, 6'd9, 6'd1}, 3'b001, {6'd9, 6'd0}, 2'b10),
            mk_out(0, 0, 0, 0, 0, 1, 0, 0, 0));
        add(mk_in(0, 1, 0, 0, 0, 0, 0, {6'd0, 6'd0, 6'd9}, 3'b001, '0, 2'b00),
            mk_out(1, 6'd9, 32'h99, 5'h00, 1, 0, 0, 0, 0));
        add(mk_in(0, 1, 0, 0, 0, 0, 0, {6'd0, 6'd0, 6'd9}, 3'b001, '0, 2'b00),
            mk_out(0, 0, 0, 0, 0, 0, 1, 0, 0));
        // Overflow while full and busy, cleared by setback.
        add(sim(1, 1, 6'd1, 32'h11, 5'h01), idle_out(1, 0, 0));
        add(sim(1, 1, 6'd2, 32'h22, 5'h02), idle_out(0, 0, 0));
        add(sim(1, 1, 6'd3, 32'h33, 5'h03), idle_out(0, 0, 0));
        add(sim(1, 1, 6'd4, 32'h44, 5'h04), idle_out(0, 1, 0));
        add(sim(1, 0, 0, 0, 0), idle_out(0, 1, 1));
        add(mk_in(1, 0, 0, 0, 0, 0, 1, '0, '0, '0, '0), idle_out(0, 1, 1));
        // Full with the port free: head retires and the new response is stored.
        add(sim(1, 1, 6'd1, 32'h11, 5'h01), idle_out(1, 0, 0));
        add(sim(1, 1, 6'd2, 32'h22, 5'h02), idle_out(0, 0, 0));
        add(sim(1, 1, 6'd3, 32'h33, 5'h03), idle_out(0, 0, 0));
        add(sim(0, 1, 6'd4, 32'h44, 5'h04), mk_out(1, 6'd1, 32'h11, 5'h01, 0, 0, 0, 1, 0));
        add(sim(0, 0, 0, 0, 0), mk_out(1, 6'd2, 32'h22, 5'h02, 0, 0, 0, 1, 0));
        add(sim(0, 0, 0, 0, 0), mk_out(1, 6'd3, 32'h33, 5'h03, 0, 0, 0, 0, 0));
        add(sim(0, 0, 0, 0, 0), mk_out(1, 6'd4, 32'h44, 5'h04, 0, 0, 0, 0, 0));
        add(sim(0, 0, 0, 0, 0), idle_out(1, 0, 0));
        // Setback with two pending and a concurrent response.
        add(sim(1, 1, 6'd10, 32'hA0, 5'h01), idle_out(1, 0, 0));
        add(sim(1, 1, 6'd11, 32'hB0, 5'h02), idle_out(0, 0, 0));
        add(mk_in(1, 1, 1, 6'd12, 32'hC0, 5'h03, 1, {6'd0, 6'd0, 6'd12}, 3'b001, '0, 2'b00),
            mk_out(0, 0, 0, 0, 1, 0, 0, 0, 0));
        add(mk_in(0, 1, 0, 0, 0, 0, 0, {6'd12, 6'd11, 6'd10}, 3'b111, {6'd11, 6'd10}, 2'b11),
            mk_out(0, 0, 0, 0, 0, 0, 1, 0, 0));
        add(sim(0, 0, 0, 0, 0), idle_out(1, 0, 0));

        repeat (2) @(negedge clk_i);
        #1;
        compare(idle_out(1, 0, 0), "reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int k = 0; k < tbl.size(); k++)
            apply(tbl[k].in, 1'b1, tbl[k].exp, $sformatf("vec%0d", k));

        // Seven responses under irregular busy: pointers wrap, arrival order must hold.
        wr_log.delete();
        for (int k = 0; k < 7; k++) begin
            bit b;
            b = (k == 0) || (k == 2) || (k == 5);
            apply(sim(b, 1, 6'(20 + k), 32'(32'h1000 + k), 5'(k)), 1'b0, '0, $sformatf("wrap%0d", k));
        end
        for (int k = 0; k < 3; k++) apply(sim(0, 0, 0, 0, 0), 1'b0, '0, $sformatf("drain%0d", k));
        check("wrap write count", wr_log.size(), 7);
        for (int k = 0; k < 7 && k < wr_log.size(); k++)
            check($sformatf("wrap order %0d", k), wr_log[k], 6'(20 + k));

        for (int n = 0; n < 600; n++) begin
            rnd        = '0;
            rnd.sb     = ($urandom_range(0, 99) < 3);
            rnd.dec    = ($urandom_range(0, 99) < 70);
            rnd.rv     = ($urandom_range(0, 99) < 55);
            rnd.busy   = ($urandom_range(0, 99) < 45);
            rnd.waddr  = 6'($urandom_range(0, 7) | ($urandom_range(0, 1) << 5));
            rnd.result = $urandom;
            rnd.flags  = 5'($urandom);
            for (int r = 0; r < 3; r++) rnd.rr[r] = 6'($urandom_range(0, 7) | ($urandom_range(0, 1) << 5));
            for (int w = 0; w < 2; w++) rnd.wr[w] = 6'($urandom_range(0, 7) | ($urandom_range(0, 1) << 5));
            rnd.rrv = 3'($urandom);
            rnd.wrv = 2'($urandom);
            apply(rnd, 1'b0, '0, $sformatf("rnd%0d", n));
        end

        // Asynchronous reset while full with overflow set.
        for (int k = 0; k < 5; k++) apply(sim(1, 1, 6'(k), 32'(k), 5'(k)), 1'b0, '0, $sformatf("prerst%0d", k));
        @(negedge clk_i);
        drive('0);
        rst_ni = 1'b0;
        #1;
        compare(idle_out(1, 0, 0), "async reset");
        mq.delete();
        m_ovf = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        apply(sim(0, 0, 0, 0, 0), 1'b0, '0, "post reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
